sd_divider: RTL

SD_DIVIDER -- requirements
Module: sd_divider

---
 rtl/sd_divider.sv | 119 +++++++++++
 1 files changed

// File: rtl/sd_divider.sv
// Sequential restoring divider: one quotient bit per ITER cycle, NUM_BITS cycles per divide.
// Divide-by-zero skips the iterations and reports all-ones quotient with the dividend as remainder.
module sd_divider #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] dividend,
    input  logic [NUM_BITS-1:0] divisor,
    output logic [NUM_BITS-1:0] quotient,
    output logic [NUM_BITS-1:0] remainder,
    output logic                busy,
    output logic                done,
    output logic                dbz,
    output logic [2:0]          s
);

    localparam int CW = $clog2(NUM_BITS) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ITER = 3'd1,
        DONE = 3'd2
    } state_t;

    state_t                state_q;
    logic [NUM_BITS:0]     r_q;
    logic [NUM_BITS-1:0]   q_q;
    logic [NUM_BITS-1:0]   d_q;
    logic [CW-1:0]         n_q;
    logic [NUM_BITS-1:0]   quotient_q;
    logic [NUM_BITS-1:0]   remainder_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  dbz_q;

    logic [NUM_BITS+1:0]   shift_d;
    logic [NUM_BITS+1:0]   trial_d;
    logic [NUM_BITS:0]     r_d;
    logic [NUM_BITS-1:0]   q_d;

    // R stays below D, so the top bit of the widened trial is a clean borrow flag.
    always_comb begin
        shift_d = {r_q, q_q[NUM_BITS-1]};
        trial_d = shift_d - {2'b00, d_q};
        q_d     = q_q << 1;
        q_d[0]  = ~trial_d[NUM_BITS+1];
        r_d     = trial_d[NUM_BITS+1] ? shift_d[NUM_BITS:0] : trial_d[NUM_BITS:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            n_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            q_q     <= dividend;
                            r_q     <= '0;
                            d_q     <= divisor;
                            n_q     <= CW'(NUM_BITS);
                            dbz_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ITER;
                        end
                    end
                end
                ITER: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    n_q <= n_q - CW'(1);
                    if (n_q == CW'(1)) begin
                        quotient_q  <= q_d;
                        remainder_q <= r_d[NUM_BITS-1:0];
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbz       = dbz_q;
    assign s         = state_q;

endmodule
